// File: rtl/xbar_slave_arb.sv
// xbar_slave_arb
//   Round-robin request arbiter for one crossbar slave port. Merges MASTERS
//   67-bit request channels into a single req/ack stream toward the
//   slave-side request buffer. Records the master index of each accepted
//   read in a tag FIFO and steers read responses back to the originating
//   master in order.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset
//   m_req_bi    per-master request
//   m_data_bi   per-master packet, master k at [k*67 +: 67]; bit 66 = write
//   m_ack_bo    per-master accept strobe (combinational)
//   m_resp_bo   per-master read-response strobe (registered)
//   m_rdata_bo  read data shared by all masters, valid with m_resp_bo
//   s_req_o     request to buffer (combinational)
//   s_data_bo   selected packet (combinational)
//   s_ack_i     buffer accept
//   s_resp_i    slave read response
//   s_rdata_bi  slave read data
//   err_o       sticky protocol error
//
// Build option
//   XBAR_ARB_ERR_EN  when defined, err_o flags a response with no
//                    outstanding tag, or a locked master changing its
//                    packet while held. When undefined err_o is tied 0.

module xbar_slave_arb #(
  parameter int MASTERS   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [MASTERS-1:0]     m_req_bi,
  input  logic [MASTERS*67-1:0]  m_data_bi,
  output logic [MASTERS-1:0]     m_ack_bo,
  output logic [MASTERS-1:0]     m_resp_bo,
  output logic [31:0]            m_rdata_bo,
  output logic                   s_req_o,
  output logic [66:0]            s_data_bo,
  input  logic                   s_ack_i,
  input  logic                   s_resp_i,
  input  logic [31:0]            s_rdata_bi,
  output logic                   err_o
);

  localparam int DW = 67;
  localparam int IW = $clog2(MASTERS);
  localparam int TW = $clog2(TAG_DEPTH);

  typedef enum logic {FREE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, lock_idx_q;
  logic [IW-1:0]   free_grant, cand, grant;
  logic [DW-1:0]   grant_data;
  logic            grant_write;
  logic            transfer;

  logic [IW-1:0]   tag_mem [TAG_DEPTH];
  logic [TW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [TW:0]     count_q;
  logic            tag_full, tag_empty, push, pop;
  logic [IW-1:0]   head;
  logic [MASTERS-1:0] head_onehot;

  // Search backwards so the lowest cyclic offset from rr_ptr wins.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    free_grant = rr_ptr_q;
    cand       = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr_q) + i) % MASTERS);
      if (m_req_bi[cand]) free_grant = cand;
    end
  end

  assign grant       = (state_q == LOCK) ? lock_idx_q : free_grant;
  assign grant_data  = m_data_bi[int'(grant)*DW +: DW];
  assign grant_write = grant_data[DW-1];

  assign tag_full  = (count_q == (TW+1)'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);

  // A read cannot be offered while no tag slot is free; writes never stall.
  assign s_req_o   = m_req_bi[grant] & ~(~grant_write & tag_full);
  assign s_data_bo = grant_data;
  assign transfer  = s_req_o & s_ack_i;

  always_comb begin
    m_ack_bo = '0;
    if (transfer) m_ack_bo[grant] = 1'b1;
  end

  // Lock holds the grant across a stalled request; it is released either by
  // the transfer or by the held master withdrawing its request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: if (s_req_o && !s_ack_i) state_d = LOCK;
      LOCK: if (transfer || !m_req_bi[lock_idx_q]) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= FREE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FREE) lock_idx_q <= free_grant;
      if (transfer) rr_ptr_q <= (grant == IW'(MASTERS-1)) ? '0 : grant + 1'b1;
    end
  end

  // Tag FIFO. tag_full is the pre-pop flag, so a pop in the same cycle does
  // not open space for a push until the next cycle.
  assign push = transfer & ~grant_write & ~tag_full;
  assign pop  = s_resp_i & ~tag_empty;
  assign head = tag_mem[rd_ptr_q];

  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < MASTERS; i++) head_onehot[i] = (head == IW'(i));
  end

  // NOTE: tag storage is not reset; pointers and count define validity, so
  // stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_q] <= grant;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_resp_bo  <= '0;
      m_rdata_bo <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      m_resp_bo <= pop ? head_onehot : '0;
      if (pop) m_rdata_bo <= s_rdata_bi;
    end
  end

`ifdef XBAR_ARB_ERR_EN
  logic [DW-1:0] lock_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_data_q <= '0;
      err_o       <= 1'b0;
    end else begin
      if (state_q == FREE) lock_data_q <= grant_data;
      if ((s_resp_i && tag_empty) ||
          (state_q == LOCK && m_req_bi[lock_idx_q] && grant_data != lock_data_q))
        err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_slave_arb.sv
// tb_xbar_slave_arb
//   Directed bench for xbar_slave_arb (MASTERS=4, TAG_DEPTH=4). Expected
//   accepts and read responses are queued as stimulus is issued; a monitor
//   pops and compares whenever the DUT strobes m_ack_bo or m_resp_bo.

module tb_xbar_slave_arb;

  localparam int M = 4;

`ifdef XBAR_ARB_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [M-1:0]    m_req_bi;
  logic [M*67-1:0] m_data_bi;
  logic [M-1:0]    m_ack_bo;
  logic [M-1:0]    m_resp_bo;
  logic [31:0]     m_rdata_bo;
  logic            s_req_o;
  logic [66:0]     s_data_bo;
  logic            s_ack_i;
  logic            s_resp_i;
  logic [31:0]     s_rdata_bi;
  logic            err_o;

  xbar_slave_arb #(.MASTERS(M), .TAG_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_bi(m_req_bi), .m_data_bi(m_data_bi), .m_ack_bo(m_ack_bo),
    .m_resp_bo(m_resp_bo), .m_rdata_bo(m_rdata_bo),
    .s_req_o(s_req_o), .s_data_bo(s_data_bo), .s_ack_i(s_ack_i),
    .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int idx; logic [66:0] data; } ack_t;
  typedef struct { logic [M-1:0] oh; logic [31:0] data; } resp_t;

  ack_t  ack_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [66:0] pkt(input int k, input bit wr, input int n);
    return {wr, 2'b00, 32'(n), 32'(k)};
  endfunction

  function automatic logic [M-1:0] onehot(input int k);
    logic [M-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic drive(input int k, input bit req, input logic [66:0] d);
    m_req_bi[k] = req;
    m_data_bi[k*67 +: 67] = d;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_ack(input int k, input logic [66:0] d);
    ack_t e;
    e.idx = k;
    e.data = d;
    ack_q.push_back(e);
  endtask

  task automatic exp_resp(input int k, input logic [31:0] d);
    resp_t e;
    e.oh = onehot(k);
    e.data = d;
    resp_q.push_back(e);
  endtask

  // Monitor: compares every strobe against the oldest queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_ack_bo != '0) begin
        if (ack_q.size() == 0) check("ack_unexpected", m_ack_bo, '0);
        else begin
          ack_t e;
          e = ack_q.pop_front();
          check("ack_grant", m_ack_bo, onehot(e.idx));
          check("ack_data", s_data_bo, e.data);
        end
      end
      if (m_resp_bo != '0) begin
        if (resp_q.size() == 0) check("resp_unexpected", m_resp_bo, '0);
        else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_onehot", m_resp_bo, r.oh);
          check("resp_rdata", m_rdata_bo, r.data);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    m_req_bi = '0;
    m_data_bi = '0;
    s_ack_i = 1'b0;
    s_resp_i = 1'b0;
    s_rdata_bi = '0;
    #3;
    check("rst_resp", m_resp_bo, '0);
    check("rst_rdata", m_rdata_bo, '0);
    check("rst_err", err_o, 1'b0);
    check("rst_s_req", s_req_o, 1'b0);
    check("rst_ack", m_ack_bo, '0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // All masters write with constant accept: grants rotate 0,1,2,3,0.
    for (int k = 0; k < M; k++) drive(k, 1'b1, pkt(k, 1'b1, 0));
    s_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_ack(i % M, pkt(i % M, 1'b1, 0));
      step();
    end
    for (int k = 0; k < M; k++) drive(k, 1'b0, '0);
    s_ack_i = 1'b0;

    // rr_ptr is now 1. Master 2 stalls 3 cycles and holds the grant even
    // though master 1 (closer to rr_ptr) begins requesting.
    drive(2, 1'b1, pkt(2, 1'b1, 2));
    @(negedge clk_i);
    check("lock_s_req", s_req_o, 1'b1);
    check("lock_data_a", s_data_bo, pkt(2, 1'b1, 2));
    step();
    drive(1, 1'b1, pkt(1, 1'b1, 1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("lock_hold_data", s_data_bo, pkt(2, 1'b1, 2));
      check("lock_no_ack", m_ack_bo, '0);
      step();
    end
    s_ack_i = 1'b1;
    exp_ack(2, pkt(2, 1'b1, 2));
    step();
    drive(2, 1'b0, '0);
    exp_ack(1, pkt(1, 1'b1, 1));
    step();
    drive(1, 1'b0, '0);
    s_ack_i = 1'b0;

    // Five reads from master 3 with no responses: four accepted, fifth stalls.
    s_ack_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(3, 1'b1, pkt(3, 1'b0, n));
      exp_ack(3, pkt(3, 1'b0, n));
      step();
    end
    drive(3, 1'b1, pkt(3, 1'b0, 4));
    @(negedge clk_i);
    check("full_stall_s_req", s_req_o, 1'b0);
    check("full_stall_ack", m_ack_bo, '0);
    step();
    // Pop while full: the read stays blocked this cycle, accepted the next.
    s_resp_i = 1'b1;
    s_rdata_bi = 32'h11;
    exp_resp(3, 32'h11);
    @(negedge clk_i);
    check("full_pop_stall", s_req_o, 1'b0);
    check("resp_latency_0", m_resp_bo, '0);
    step();
    s_resp_i = 1'b0;
    exp_ack(3, pkt(3, 1'b0, 4));
    step();
    drive(3, 1'b0, '0);

    // FIFO holds four tags of master 3. A read from master 0 waits out a
    // pop, then is queued behind the master-3 tags during a push+pop cycle.
    drive(0, 1'b1, pkt(0, 1'b0, 7));
    s_resp_i = 1'b1;
    s_rdata_bi = 32'h31;
    exp_resp(3, 32'h31);
    @(negedge clk_i);
    check("full_pp_stall", s_req_o, 1'b0);
    step();
    exp_ack(0, pkt(0, 1'b0, 7));
    s_rdata_bi = 32'h32;
    exp_resp(3, 32'h32);
    step();
    drive(0, 1'b0, '0);
    s_ack_i = 1'b0;
    s_rdata_bi = 32'h33;
    exp_resp(3, 32'h33);
    step();
    s_rdata_bi = 32'h34;
    exp_resp(3, 32'h34);
    step();
    s_rdata_bi = 32'h35;
    exp_resp(0, 32'h35);
    step();
    s_resp_i = 1'b0;

    // Reads from 0, 2, 1 then three responses returned in order.
    s_ack_i = 1'b1;
    drive(0, 1'b1, pkt(0, 1'b0, 8));
    exp_ack(0, pkt(0, 1'b0, 8));
    step();
    drive(0, 1'b0, '0);
    drive(2, 1'b1, pkt(2, 1'b0, 9));
    exp_ack(2, pkt(2, 1'b0, 9));
    step();
    drive(2, 1'b0, '0);
    drive(1, 1'b1, pkt(1, 1'b0, 10));
    exp_ack(1, pkt(1, 1'b0, 10));
    step();
    drive(1, 1'b0, '0);
    s_ack_i = 1'b0;
    s_resp_i = 1'b1;
    s_rdata_bi = 32'hA;
    exp_resp(0, 32'hA);
    @(negedge clk_i);
    check("resp_latency_1", m_resp_bo, '0);
    step();
    s_rdata_bi = 32'hB;
    exp_resp(2, 32'hB);
    step();
    s_rdata_bi = 32'hC;
    exp_resp(1, 32'hC);
    step();
    s_resp_i = 1'b0;
    step();
    @(negedge clk_i);
    check("resp_single_pulse", m_resp_bo, '0);
    check("rdata_hold", m_rdata_bo, 32'hC);
    check("err_clean", err_o, 1'b0);
    step();

    // Response with an empty FIFO.
    s_resp_i = 1'b1;
    s_rdata_bi = 32'hDEAD;
    step();
    s_resp_i = 1'b0;
    @(negedge clk_i);
    check("empty_resp_none", m_resp_bo, '0);
    check("empty_rdata_hold", m_rdata_bo, 32'hC);
    check("empty_err", err_o, EXP_ERR);
    step();

    // Leave a tag outstanding, lock master 1, then reset mid-stall.
    s_ack_i = 1'b1;
    drive(2, 1'b1, pkt(2, 1'b0, 11));
    exp_ack(2, pkt(2, 1'b0, 11));
    step();
    drive(2, 1'b0, '0);
    s_ack_i = 1'b0;
    drive(1, 1'b1, pkt(1, 1'b1, 12));
    step();
    drive(0, 1'b1, pkt(0, 1'b1, 13));
    @(negedge clk_i);
    check("pre_rst_lock", s_data_bo, pkt(1, 1'b1, 12));
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_resp", m_resp_bo, '0);
    check("mid_rst_rdata", m_rdata_bo, '0);
    check("mid_rst_err", err_o, 1'b0);
    check("mid_rst_unlock", s_data_bo, pkt(0, 1'b1, 13));
    check("mid_rst_ack", m_ack_bo, '0);
    step();
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    #1;
    check("rst_idle_s_req", s_req_o, 1'b0);
    step();
    rst_i = 1'b0;
    // Stale response for the discarded tag.
    s_resp_i = 1'b1;
    s_rdata_bi = 32'hBEEF;
    step();
    s_resp_i = 1'b0;
    @(negedge clk_i);
    check("stale_resp_none", m_resp_bo, '0);
    check("stale_rdata", m_rdata_bo, '0);
    check("stale_err", err_o, EXP_ERR);
    step();
    step();

    check("ack_q_drained", 128'(ack_q.size()), '0);
    check("resp_q_drained", 128'(resp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
